// File: rtl/logic_op_checker.sv
// Response checker for a logic-unit slice: recomputes AND/OR/XOR/NOR and tallies pass/fail.
// Define LOGIC_OP_CHECKER_FIRST_FAIL_EN to capture the operands and result of a run's first mismatch.
module logic_op_checker #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MAX_SAMPLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       op,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             mismatch,
  output logic             first_fail_vld,
  output logic [WIDTH-1:0] first_fail_a,
  output logic [WIDTH-1:0] first_fail_b,
  output logic [WIDTH-1:0] first_fail_y
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state;
  logic [1:0]       op_q;
  logic [31:0]      sample_cnt;
  logic [31:0]      sample_cnt_inc;
  logic [WIDTH-1:0] expected;
  logic             accept;
  logic             match;
  logic             limit_hit;

  always_comb begin
    expected = '0;
    case (op_q)
      2'b00:   expected = a & b;
      2'b01:   expected = a | b;
      2'b10:   expected = a ^ b;
      default: expected = ~(a | b);
    endcase
  end

  // A start in the same cycle discards the sample.
  assign accept         = (state == StRun) && sample_valid && !start;
  assign match          = (expected == y);
  assign sample_cnt_inc = (sample_cnt == '1) ? sample_cnt : sample_cnt + 32'd1;
  assign limit_hit      = (MAX_SAMPLES != 0) && (sample_cnt_inc == 32'(MAX_SAMPLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      op_q       <= 2'b00;
      sample_cnt <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      mismatch   <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (start) begin
        state      <= StRun;
        busy       <= 1'b1;
        done       <= 1'b0;
        op_q       <= op;
        sample_cnt <= '0;
        pass_cnt   <= '0;
        fail_cnt   <= '0;
      end else if (state == StRun) begin
        if (accept) begin
          sample_cnt <= sample_cnt_inc;
          if (match) begin
            if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
          end else begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
            mismatch <= 1'b1;
          end
        end
        if (stop || (accept && limit_hit)) begin
          state <= StDone;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

`ifdef LOGIC_OP_CHECKER_FIRST_FAIL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_vld <= 1'b0;
      first_fail_a   <= '0;
      first_fail_b   <= '0;
      first_fail_y   <= '0;
    end else if (start) begin
      first_fail_vld <= 1'b0;
      first_fail_a   <= '0;
      first_fail_b   <= '0;
      first_fail_y   <= '0;
    end else if (accept && !match && !first_fail_vld) begin
      first_fail_vld <= 1'b1;
      first_fail_a   <= a;
      first_fail_b   <= b;
      first_fail_y   <= y;
    end
  end
`else
  assign first_fail_vld = 1'b0;
  assign first_fail_a   = '0;
  assign first_fail_b   = '0;
  assign first_fail_y   = '0;
`endif

endmodule

// File: tb/tb_logic_op_checker.sv
// Randomized self-checking bench for logic_op_checker; three instances cover default,
// MAX_SAMPLES=3 and CNT_W=2 configurations sharing one stimulus stream.
module tb_logic_op_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        sample_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] y = '0;

  logic        m_busy, m_done, m_mismatch, m_ff_vld;
  logic [15:0] m_pass, m_fail;
  logic [31:0] m_ff_a, m_ff_b, m_ff_y;
  logic        x_busy, x_done, x_mismatch, x_ff_vld;
  logic [15:0] x_pass, x_fail;
  logic [31:0] x_ff_a, x_ff_b, x_ff_y;
  logic        s_busy, s_done, s_mismatch, s_ff_vld;
  logic [1:0]  s_pass, s_fail;
  logic [31:0] s_ff_a, s_ff_b, s_ff_y;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  logic_op_checker #(.WIDTH(32), .CNT_W(16), .MAX_SAMPLES(0)) dut_main (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .op(op),
    .sample_valid(sample_valid), .a(a), .b(b), .y(y),
    .busy(m_busy), .done(m_done), .pass_cnt(m_pass), .fail_cnt(m_fail),
    .mismatch(m_mismatch), .first_fail_vld(m_ff_vld),
    .first_fail_a(m_ff_a), .first_fail_b(m_ff_b), .first_fail_y(m_ff_y)
  );

  logic_op_checker #(.WIDTH(32), .CNT_W(16), .MAX_SAMPLES(3)) dut_max (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .op(op),
    .sample_valid(sample_valid), .a(a), .b(b), .y(y),
    .busy(x_busy), .done(x_done), .pass_cnt(x_pass), .fail_cnt(x_fail),
    .mismatch(x_mismatch), .first_fail_vld(x_ff_vld),
    .first_fail_a(x_ff_a), .first_fail_b(x_ff_b), .first_fail_y(x_ff_y)
  );

  logic_op_checker #(.WIDTH(32), .CNT_W(2), .MAX_SAMPLES(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .op(op),
    .sample_valid(sample_valid), .a(a), .b(b), .y(y),
    .busy(s_busy), .done(s_done), .pass_cnt(s_pass), .fail_cnt(s_fail),
    .mismatch(s_mismatch), .first_fail_vld(s_ff_vld),
    .first_fail_a(s_ff_a), .first_fail_b(s_ff_b), .first_fail_y(s_ff_y)
  );

  // Reference behaviour: NOR written via De Morgan, the others straight from the op table.
  function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] x,
                                         input logic [31:0] z);
    case (o)
      2'd0:    return x & z;
      2'd1:    return x | z;
      2'd2:    return x ^ z;
      default: return ~x & ~z;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
  endtask

  task automatic begin_run(input logic [1:0] o);
    start = 1'b1; op = o; sample_valid = 1'b0; stop = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_total++; if (m_busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", m_busy);
    else n_pass++;
    n_total++; if (m_done !== 1'b0) $display("FAIL rst_done: got %0b want 0", m_done);
    else n_pass++;
    n_total++; if (m_pass !== 16'd0 || m_fail !== 16'd0)
      $display("FAIL rst_cnt: got %0d/%0d want 0/0", m_pass, m_fail);
    else n_pass++;
    n_total++; if (m_mismatch !== 1'b0 || m_ff_vld !== 1'b0 || m_ff_y !== 32'd0)
      $display("FAIL rst_ff: got mis=%0b vld=%0b y=%0h want 0", m_mismatch, m_ff_vld, m_ff_y);
    else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_and_truth();
    logic [31:0] ta [4] = '{32'd0, 32'd0, 32'd1, 32'd1};
    logic [31:0] tb [4] = '{32'd0, 32'd1, 32'd0, 32'd1};
    logic [31:0] ty [4] = '{32'd0, 32'd0, 32'd0, 32'd1};
    int mis_seen = 0;
    begin_run(2'b00);
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1; a = ta[i]; b = tb[i]; y = ty[i];
      step();
      if (m_mismatch) mis_seen++;
    end
    sample_valid = 1'b0; stop = 1'b1;
    step();
    if (m_mismatch) mis_seen++;
    stop = 1'b0;
    n_total++; if (m_pass !== 16'd4) $display("FAIL and_pass: got %0d want 4", m_pass);
    else n_pass++;
    n_total++; if (m_fail !== 16'd0) $display("FAIL and_fail: got %0d want 0", m_fail);
    else n_pass++;
    n_total++; if (m_done !== 1'b1 || m_busy !== 1'b0)
      $display("FAIL and_done: got done=%0b busy=%0b want 1/0", m_done, m_busy);
    else n_pass++;
    n_total++; if (mis_seen != 0) $display("FAIL and_mismatch: got %0d pulses want 0", mis_seen);
    else n_pass++;
  endtask

  task automatic test_first_fail();
    begin_run(2'b00);
    sample_valid = 1'b1; a = 32'hFFFF0000; b = 32'h0F0F0F0F; y = 32'h0F0F0F0F;
    step();
    n_total++; if (m_mismatch !== 1'b1) $display("FAIL ff_pulse: got %0b want 1", m_mismatch);
    else n_pass++;
    n_total++; if (m_fail !== 16'd1) $display("FAIL ff_fail1: got %0d want 1", m_fail);
    else n_pass++;
`ifdef LOGIC_OP_CHECKER_FIRST_FAIL_EN
    n_total++; if (m_ff_vld !== 1'b1 || m_ff_y !== 32'h0F0F0F0F)
      $display("FAIL ff_capture: got vld=%0b y=%0h want 1/0f0f0f0f", m_ff_vld, m_ff_y);
    else n_pass++;
`else
    n_total++; if (m_ff_vld !== 1'b0 || m_ff_y !== 32'd0)
      $display("FAIL ff_tied: got vld=%0b y=%0h want 0/0", m_ff_vld, m_ff_y);
    else n_pass++;
`endif
    a = 32'd1; b = 32'd1; y = 32'd0;
    step();
    sample_valid = 1'b0;
    n_total++; if (m_fail !== 16'd2) $display("FAIL ff_fail2: got %0d want 2", m_fail);
    else n_pass++;
`ifdef LOGIC_OP_CHECKER_FIRST_FAIL_EN
    n_total++; if (m_ff_a !== 32'hFFFF0000 || m_ff_b !== 32'h0F0F0F0F || m_ff_y !== 32'h0F0F0F0F)
      $display("FAIL ff_hold: got %0h %0h %0h", m_ff_a, m_ff_b, m_ff_y);
    else n_pass++;
`else
    n_total++; if (m_ff_a !== 32'd0 || m_ff_b !== 32'd0)
      $display("FAIL ff_tied2: got %0h %0h want 0 0", m_ff_a, m_ff_b);
    else n_pass++;
`endif
    step();
    n_total++; if (m_mismatch !== 1'b0) $display("FAIL ff_pulse_end: got %0b want 0", m_mismatch);
    else n_pass++;
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_idle_ignore();
    // Still in DONE from the previous run: samples are ignored and results hold.
    sample_valid = 1'b1; a = 32'h5; b = 32'h3; y = 32'hFF;
    step();
    sample_valid = 1'b0;
    n_total++; if (m_mismatch !== 1'b0 || m_fail !== 16'd2)
      $display("FAIL idle_ignore: got mis=%0b fail=%0d want 0/2", m_mismatch, m_fail);
    else n_pass++;
  endtask

  task automatic test_max_samples();
    begin_run(2'b11);
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1; a = $urandom; b = $urandom; y = ref_op(2'b11, a, b);
      step();
      if (i == 2) begin
        n_total++; if (x_done !== 1'b1 || x_busy !== 1'b0 || x_pass !== 16'd3)
          $display("FAIL max_done: got done=%0b busy=%0b pass=%0d want 1/0/3",
                   x_done, x_busy, x_pass);
        else n_pass++;
      end
    end
    sample_valid = 1'b0;
    step();
    n_total++; if (x_pass !== 16'd3 || x_fail !== 16'd0)
      $display("FAIL max_ignore: got %0d/%0d want 3/0", x_pass, x_fail);
    else n_pass++;
    n_total++; if (m_pass !== 16'd5 || m_busy !== 1'b1)
      $display("FAIL max_unlimited: got pass=%0d busy=%0b want 5/1", m_pass, m_busy);
    else n_pass++;
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_collisions();
    begin_run(2'b01);
    for (int i = 0; i < 2; i++) begin
      sample_valid = 1'b1; a = $urandom; b = $urandom; y = ref_op(2'b01, a, b);
      step();
    end
    n_total++; if (m_pass !== 16'd2) $display("FAIL col_pre: got %0d want 2", m_pass);
    else n_pass++;
    start = 1'b1; op = 2'b10; a = 32'h1; b = 32'h2; y = 32'h3;
    step();
    n_total++; if (m_pass !== 16'd0 || m_fail !== 16'd0 || m_busy !== 1'b1)
      $display("FAIL col_restart: got %0d/%0d busy=%0b want 0/0/1", m_pass, m_fail, m_busy);
    else n_pass++;
    sample_valid = 1'b0; stop = 1'b1; op = 2'b00;
    step();
    n_total++; if (m_busy !== 1'b1 || m_done !== 1'b0)
      $display("FAIL col_start_stop: got busy=%0b done=%0b want 1/0", m_busy, m_done);
    else n_pass++;
    start = 1'b0; stop = 1'b1; sample_valid = 1'b1;
    a = 32'hA5A5_0000; b = 32'h0000_5A5A; y = ref_op(2'b00, a, b);
    step();
    idle_inputs();
    n_total++; if (m_pass !== 16'd1 || m_done !== 1'b1 || m_busy !== 1'b0)
      $display("FAIL col_stop_sample: got pass=%0d done=%0b busy=%0b want 1/1/0",
               m_pass, m_done, m_busy);
    else n_pass++;
  endtask

  task automatic test_saturation();
    begin_run(2'b10);
    for (int i = 0; i < 6; i++) begin
      sample_valid = 1'b1; a = $urandom; b = $urandom; y = ref_op(2'b10, a, b) ^ 32'h1;
      step();
    end
    sample_valid = 1'b0;
    n_total++; if (s_fail !== 2'd3) $display("FAIL sat_fail: got %0d want 3", s_fail);
    else n_pass++;
    n_total++; if (m_fail !== 16'd6) $display("FAIL sat_wide: got %0d want 6", m_fail);
    else n_pass++;
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_random();
    int exp_pass;
    int exp_fail;
    logic exp_mis;
    logic [1:0] run_op;
    for (int r = 0; r < 4; r++) begin
      run_op = 2'($urandom_range(0, 3));
      begin_run(run_op);
      exp_pass = 0; exp_fail = 0;
      for (int i = 0; i < 40; i++) begin
        sample_valid = ($urandom_range(0, 3) != 0);
        op = 2'($urandom);  // ignored outside start
        a = $urandom; b = $urandom;
        y = ref_op(run_op, a, b);
        if ($urandom_range(0, 3) == 0) y = y ^ (32'h1 << $urandom_range(0, 31));
        exp_mis = 1'b0;
        if (sample_valid) begin
          if (y == ref_op(run_op, a, b)) exp_pass++;
          else begin exp_fail++; exp_mis = 1'b1; end
        end
        step();
        n_total++; if (m_mismatch !== exp_mis || m_pass !== 16'(exp_pass)
                       || m_fail !== 16'(exp_fail))
          $display("FAIL rand_r%0d_c%0d: got mis=%0b %0d/%0d want %0b %0d/%0d", r, i,
                   m_mismatch, m_pass, m_fail, exp_mis, exp_pass, exp_fail);
        else n_pass++;
      end
      idle_inputs(); stop = 1'b1;
      step();
      stop = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    begin_run(2'b00);
    sample_valid = 1'b1; a = 32'hF0; b = 32'hFF; y = 32'h0F;
    step();
    sample_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_total++; if (m_busy !== 1'b0 || m_done !== 1'b0 || m_fail !== 16'd0
                   || m_mismatch !== 1'b0 || m_ff_vld !== 1'b0)
      $display("FAIL async_rst: got busy=%0b done=%0b fail=%0d mis=%0b vld=%0b want 0",
               m_busy, m_done, m_fail, m_mismatch, m_ff_vld);
    else n_pass++;
    step();
    rst_n = 1'b1;
    step();
    n_total++; if (m_busy !== 1'b0 || m_done !== 1'b0)
      $display("FAIL async_release: got busy=%0b done=%0b want 0/0", m_busy, m_done);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_and_truth();
    test_first_fail();
    test_idle_ignore();
    test_max_samples();
    test_collisions();
    test_saturation();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/logic_op_checker.md
# logic_op_checker

Synthesizable response checker for the logic-unit path of the 32-bit MIPS single-cycle datapath. It consumes the operand/result stream a stimulus source drives into a gate or ALU logic slice, recomputes the expected result for the selected operation, and tallies passes and failures. It sits beside the unit under test as the observing end of the stimulus interface and gives on-chip pass/fail status without waveform inspection.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits
- CNT_W, 16, width of the pass and fail counters
- MAX_SAMPLES, 0, number of samples after which the run ends automatically; 0 means unlimited

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: clear results, latch op, enter RUN
- stop  in  1  one-cycle pulse: end the run (RUN→DONE)
- op  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR; sampled only on start
- sample_valid  in  1  a/b/y are valid this cycle
- a  in  WIDTH  operand A driven to the unit under test
- b  in  WIDTH  operand B
- y  in  WIDTH  result returned by the unit under test
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass_cnt  out  CNT_W  matching samples
- fail_cnt  out  CNT_W  mismatching samples
- mismatch  out  1  one-cycle pulse for each failing sample
- first_fail_vld  out  1  first-failure record is valid
- first_fail_a, first_fail_b, first_fail_y  out  WIDTH  operands and result of the first failing sample

## Operation
- States: IDLE (reset), RUN, DONE.
- IDLE/DONE + start → RUN. Counters, first_fail_* and the sample count clear; op_q ← op.
- RUN + start → restart: same clearing, op re-latched, stays in RUN. A sample in the same cycle is discarded.
- RUN + stop → DONE.
- RUN, MAX_SAMPLES≠0, accepted sample count reaches MAX_SAMPLES → DONE on that same edge.
- Sample acceptance: only in RUN with sample_valid=1 and start=0.
- Expected result: a&b, a|b, a^b or ~(a|b), using op_q. Full WIDTH-bit equality compare against y.
- On a match pass_cnt increments. On a mismatch fail_cnt increments and mismatch pulses.
- Both counters saturate at 2^CNT_W−1. The internal sample count is 32 bits and also saturates.
- sample_valid in IDLE/DONE is ignored: no counting and no pulse.
- start and stop in the same cycle: start wins.
- stop together with an accepted sample: the sample is counted, then DONE.
- Counters and first_fail_* hold their values in DONE until the next start.

## Timing
- All outputs are registered. Reset values: busy=0, done=0, pass_cnt=0, fail_cnt=0, mismatch=0, first_fail_vld=0, first_fail_a/b/y=0.
- Latency: a sample accepted at edge N shows in pass_cnt/fail_cnt/mismatch/first_fail_* after edge N, i.e. visible in cycle N+1.
- busy and done change on the edge that changes state.
- Throughput: one sample per cycle, no back-pressure.
- rst_n assertion mid-run clears all state and outputs immediately, asynchronously. Release is sampled on a clk edge.

## Configuration
- LOGIC_OP_CHECKER_FIRST_FAIL_EN defined: on the first mismatch of a run, capture a, b, y into first_fail_a/b/y and set first_fail_vld. Later mismatches do not overwrite the capture.
- Not defined: no capture registers. first_fail_vld and first_fail_a/b/y are tied to 0. Counters and mismatch are unaffected.

## Test plan
- Reset, then start with op=00. Apply (a,b,y) = (0,0,0), (0,1,0), (1,0,0), (1,1,1) with WIDTH=32 zero-extended, then stop → pass_cnt=4, fail_cnt=0, done=1, mismatch never pulses.
- op=00, sample a=32'hFFFF0000, b=32'h0F0F0F0F, y=32'h0F0F0F0F → mismatch pulse one cycle later, fail_cnt=1. With the macro defined, first_fail_vld=1 and first_fail_y=32'h0F0F0F0F. A second bad sample leaves the capture unchanged.
- MAX_SAMPLES=3, op=11, five back-to-back correct NOR samples → pass_cnt=3, done=1 after the third sample, remaining samples ignored.
- Restart and collisions: start in RUN after 2 samples → counters read 0 next cycle. start+stop in the same cycle → stays busy. stop with a valid sample → sample counted, done=1.
- CNT_W=2, 6 failing samples → fail_cnt saturates at 3.
- Drop rst_n mid-run between edges → all outputs 0 immediately. After release, the state is IDLE (busy=0, done=0).
